// File: rtl/eth_frame_gen.sv
// AXI-Stream Ethernet test-frame generator: fixed header, sequence number, byte-index payload, swept lengths.
// Optional macro FRAME_GEN_RAND_LEN_EN replaces the length sweep with LFSR-driven random lengths.
module eth_frame_gen #(
  parameter logic [7:0]  P_MIN_LENGTH = 8'd64,
  parameter logic [14:0] P_MAX_LENGTH = 15'd9600,
  parameter logic [15:0] P_LEN_STEP   = 16'd1,
  parameter logic [7:0]  P_GAP_CYCLES = 8'd4,
  parameter logic [47:0] P_DST_MAC    = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] P_SRC_MAC    = 48'h0A0B_0C0D_0E0F,
  parameter logic [15:0] P_ETH_TYPE   = 16'h88B5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  output logic [63:0] o_axis_tdata,
  output logic [7:0]  o_axis_tkeep,
  output logic        o_axis_tlast,
  output logic        o_axis_tvalid,
  input  logic        i_axis_tready,
  output logic [31:0] o_frame_cnt,
  output logic [15:0] o_cur_length,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam logic [15:0] MIN_LEN = {8'd0, P_MIN_LENGTH};
  localparam logic [15:0] MAX_LEN = {1'b0, P_MAX_LENGTH};

  state_t      state_reg, state_next;
  logic [15:0] len_reg, len_next;
  logic [31:0] seq_reg, seq_next;
  logic [15:0] beat_idx_reg, beat_idx_next;
  logic [7:0]  gap_cnt_reg, gap_cnt_next;
  logic [31:0] frame_cnt_reg, frame_cnt_next;
  logic [15:0] cur_length_reg, cur_length_next;
  logic [63:0] tdata_reg, tdata_next;
  logic [7:0]  tkeep_reg, tkeep_next;
  logic        tlast_reg, tlast_next;
  logic        tvalid_reg, tvalid_next;

  logic        handshake;
  logic        frame_done;
  logic [15:0] len_after;
  logic        load;

  assign handshake  = tvalid_reg & i_axis_tready;
  assign frame_done = handshake & tlast_reg;

`ifdef FRAME_GEN_RAND_LEN_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [15:0] lfsr_reg;
  logic [15:0] lfsr_step;
  logic [15:0] rand_len;

  assign lfsr_step = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
  assign rand_len  = MIN_LEN + {2'b00, lfsr_step[13:0]};
  assign len_after = (rand_len > MAX_LEN) ? MAX_LEN : rand_len;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lfsr_reg <= LFSR_SEED;
    end else if (state_reg == IDLE && i_enable) begin
      lfsr_reg <= LFSR_SEED;
    end else if (frame_done) begin
      lfsr_reg <= lfsr_step;
    end
  end
`else
  logic [16:0] sweep_sum;

  assign sweep_sum = {1'b0, len_reg} + {1'b0, P_LEN_STEP};
  assign len_after = (sweep_sum > {1'b0, MAX_LEN}) ? MIN_LEN : sweep_sum[15:0];
`endif

  // Identify the beat that would be loaded into the output register this cycle.
  logic [15:0] sel_len;
  logic [31:0] sel_seq;
  logic [15:0] sel_idx;

  always_comb begin
    sel_len = len_reg;
    sel_seq = seq_reg;
    sel_idx = 16'd0;
    case (state_reg)
      IDLE: begin
        sel_len = MIN_LEN;
        sel_seq = 32'd0;
      end
      SEND: begin
        if (frame_done) begin
          sel_len = len_after;
          sel_seq = seq_reg + 32'd1;
        end else begin
          sel_idx = beat_idx_reg + 16'd1;
        end
      end
      default: ;
    endcase
  end

  logic [143:0] header;
  logic [7:0]   hdr_bytes [0:17];
  logic [18:0]  beat_base;
  logic [63:0]  beat_data;
  logic [7:0]   beat_keep;
  logic         beat_last;

  assign header    = {P_DST_MAC, P_SRC_MAC, P_ETH_TYPE, sel_seq};
  assign beat_base = {sel_idx, 3'b000};
  assign beat_last = (beat_base + 19'd8) >= {3'b000, sel_len};

  genvar gi;
  generate
    for (gi = 0; gi < 18; gi++) begin : g_hdr
      assign hdr_bytes[gi] = header[143 - 8*gi -: 8];
    end

    // Invalid lanes are forced to zero so the tail of the last beat is clean.
    for (gi = 0; gi < 8; gi++) begin : g_lane
      logic [18:0] k;
      assign k = beat_base + 19'(gi);
      assign beat_keep[gi] = (k < {3'b000, sel_len});
      assign beat_data[gi*8 +: 8] = !beat_keep[gi] ? 8'h00 :
                                    (k < 19'd18)   ? hdr_bytes[k[4:0]] : k[7:0];
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    len_next        = len_reg;
    seq_next        = seq_reg;
    beat_idx_next   = beat_idx_reg;
    gap_cnt_next    = gap_cnt_reg;
    frame_cnt_next  = frame_cnt_reg;
    cur_length_next = cur_length_reg;
    tdata_next      = tdata_reg;
    tkeep_next      = tkeep_reg;
    tlast_next      = tlast_reg;
    tvalid_next     = tvalid_reg;
    load            = 1'b0;

    case (state_reg)
      IDLE: begin
        if (i_enable) begin
          state_next      = SEND;
          len_next        = MIN_LEN;
          seq_next        = 32'd0;
          beat_idx_next   = 16'd0;
          cur_length_next = MIN_LEN;
          load            = 1'b1;
        end
      end
      SEND: begin
        if (handshake) begin
          if (!tlast_reg) begin
            beat_idx_next = sel_idx;
            load          = 1'b1;
          end else begin
            frame_cnt_next = frame_cnt_reg + 32'd1;
            len_next       = len_after;
            seq_next       = seq_reg + 32'd1;
            beat_idx_next  = 16'd0;
            if (P_GAP_CYCLES != 8'd0) begin
              state_next   = GAP;
              gap_cnt_next = 8'd0;
            end else if (i_enable) begin
              cur_length_next = len_after;
              load            = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end
        end
      end
      GAP: begin
        if (gap_cnt_reg == P_GAP_CYCLES - 8'd1) begin
          if (i_enable) begin
            state_next      = SEND;
            cur_length_next = len_reg;
            load            = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          gap_cnt_next = gap_cnt_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Output beat only changes on a load or at the closing handshake, so stalls hold it.
    if (load) begin
      tdata_next  = beat_data;
      tkeep_next  = beat_keep;
      tlast_next  = beat_last;
      tvalid_next = 1'b1;
    end else if (handshake) begin
      tdata_next  = 64'd0;
      tkeep_next  = 8'd0;
      tlast_next  = 1'b0;
      tvalid_next = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg      <= IDLE;
      len_reg        <= MIN_LEN;
      seq_reg        <= 32'd0;
      beat_idx_reg   <= 16'd0;
      gap_cnt_reg    <= 8'd0;
      frame_cnt_reg  <= 32'd0;
      cur_length_reg <= 16'd0;
      tdata_reg      <= 64'd0;
      tkeep_reg      <= 8'd0;
      tlast_reg      <= 1'b0;
      tvalid_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      len_reg        <= len_next;
      seq_reg        <= seq_next;
      beat_idx_reg   <= beat_idx_next;
      gap_cnt_reg    <= gap_cnt_next;
      frame_cnt_reg  <= frame_cnt_next;
      cur_length_reg <= cur_length_next;
      tdata_reg      <= tdata_next;
      tkeep_reg      <= tkeep_next;
      tlast_reg      <= tlast_next;
      tvalid_reg     <= tvalid_next;
    end
  end

  assign o_axis_tdata  = tdata_reg;
  assign o_axis_tkeep  = tkeep_reg;
  assign o_axis_tlast  = tlast_reg;
  assign o_axis_tvalid = tvalid_reg;
  assign o_frame_cnt   = frame_cnt_reg;
  assign o_cur_length  = cur_length_reg;
  assign o_busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_eth_frame_gen.sv
// Self-checking bench for eth_frame_gen: default instance plus a short-sweep, zero-gap instance.
module tb_eth_frame_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en_a, en_b;
  logic        tready_a, tready_b;
  logic [63:0] tdata_a, tdata_b;
  logic [7:0]  tkeep_a, tkeep_b;
  logic        tlast_a, tlast_b, tvalid_a, tvalid_b;
  logic [31:0] fcnt_a, fcnt_b;
  logic [15:0] clen_a, clen_b;
  logic        busy_a, busy_b;

  eth_frame_gen dut_a (
    .i_clk(clk), .i_rst(rst), .i_enable(en_a),
    .o_axis_tdata(tdata_a), .o_axis_tkeep(tkeep_a), .o_axis_tlast(tlast_a),
    .o_axis_tvalid(tvalid_a), .i_axis_tready(tready_a),
    .o_frame_cnt(fcnt_a), .o_cur_length(clen_a), .o_busy(busy_a)
  );

  eth_frame_gen #(
    .P_MIN_LENGTH(8'd64), .P_MAX_LENGTH(15'd66), .P_LEN_STEP(16'd1), .P_GAP_CYCLES(8'd0)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_enable(en_b),
    .o_axis_tdata(tdata_b), .o_axis_tkeep(tkeep_b), .o_axis_tlast(tlast_b),
    .o_axis_tvalid(tvalid_b), .i_axis_tready(tready_b),
    .o_frame_cnt(fcnt_b), .o_cur_length(clen_b), .o_busy(busy_b)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [15:0] cur_len;
    int          cyc;
  } beat_t;

  typedef struct {
    int          idx;
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [15:0] len;
  } vec_t;

  beat_t beats_a[$];
  beat_t beats_b[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  logic  rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int seq, input int k);
    logic [47:0] dst = 48'hFFFF_FFFF_FFFF;
    logic [47:0] src = 48'h0A0B_0C0D_0E0F;
    logic [31:0] s   = 32'(seq);
    if (k < 6)   return dst[8*(5-k) +: 8];
    if (k < 12)  return src[8*(11-k) +: 8];
    if (k == 12) return 8'h88;
    if (k == 13) return 8'hB5;
    if (k < 18)  return s[8*(17-k) +: 8];
    return 8'(k);
  endfunction

  task automatic exp_beat(input int len, input int seq, input int b,
                          output logic [63:0] d, output logic [7:0] kp, output logic l);
    d  = 64'd0;
    kp = 8'd0;
    for (int j = 0; j < 8; j++) begin
      if (8*b + j < len) begin
        d[8*j +: 8] = exp_byte(seq, 8*b + j);
        kp[j] = 1'b1;
      end
    end
    l = (8*b + 8 >= len);
  endtask

  function automatic int n_last(input int sel);
    int n = 0;
    if (sel == 0) begin
      foreach (beats_a[i]) if (beats_a[i].last) n++;
    end else begin
      foreach (beats_b[i]) if (beats_b[i].last) n++;
    end
    return n;
  endfunction

  // One comparison for the length report plus one for the whole frame's beats.
  task automatic check_frame(input string tag, input int sel, inout int pos, input int len, input int seq);
    int bad = 0;
    int qsize;
    beat_t bt;
    logic [63:0] ed;
    logic [7:0]  ek;
    logic        el;
    for (int b = 0; b < (len + 7) / 8; b++) begin
      qsize = (sel == 0) ? beats_a.size() : beats_b.size();
      if (pos >= qsize) begin
        bad++;
        break;
      end
      if (sel == 0) bt = beats_a[pos];
      else          bt = beats_b[pos];
      if (b == 0) check($sformatf("%s_cur_length", tag), bt.cur_len, len);
      exp_beat(len, seq, b, ed, ek, el);
      if (bt.data !== ed || bt.keep !== ek || bt.last !== el) bad++;
      pos++;
    end
    check($sformatf("%s_bad_beats", tag), bad, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    en_a = 1'b0;
    en_b = 1'b0;
    rand_ready = 1'b0;
    tready_a = 1'b1;
    beats_a.delete();
    beats_b.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_frames(input int sel, input int n, input int budget);
    for (int i = 0; i < budget && n_last(sel) < n; i++) @(negedge clk);
    check($sformatf("wait_frames_dut%0d_%0d", sel, n), n_last(sel) >= n, 1'b1);
  endtask

  task automatic wait_beats_a(input int n, input int budget);
    for (int i = 0; i < budget && beats_a.size() < n; i++) @(negedge clk);
    check($sformatf("wait_beats_%0d", n), beats_a.size() >= n, 1'b1);
  endtask

  task automatic wait_idle_a(input int budget, output int fall_cyc);
    fall_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy_a) begin
        fall_cyc = cyc;
        break;
      end
    end
    check("wait_idle", fall_cyc >= 0, 1'b1);
  endtask

  // Monitor for dut_a: captures handshakes and checks that stalled beats hold steady.
  initial begin
    logic        stall = 1'b0;
    logic [73:0] prev  = '0;
    beat_t bt;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) check("stall_hold", {tvalid_a, tlast_a, tkeep_a, tdata_a}, prev);
        if (tvalid_a && tready_a) begin
          bt.data = tdata_a; bt.keep = tkeep_a; bt.last = tlast_a;
          bt.cur_len = clen_a; bt.cyc = cyc;
          beats_a.push_back(bt);
        end
        stall = tvalid_a && !tready_a;
        prev  = {tvalid_a, tlast_a, tkeep_a, tdata_a};
      end
    end
  end

  initial begin
    beat_t bt;
    forever begin
      @(negedge clk);
      if (!rst && tvalid_b && tready_b) begin
        bt.data = tdata_b; bt.keep = tkeep_b; bt.last = tlast_b;
        bt.cur_len = clen_b; bt.cyc = cyc;
        beats_b.push_back(bt);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) tready_a = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    vec_t tbl[8];
    int pos;
    int fall;
    int vcnt;
    int bad;
    int lens[5];

    tbl[0] = '{0,  64'h0B0A_FFFF_FFFF_FFFF, 8'hFF, 1'b0, 16'd64};
    tbl[1] = '{1,  64'h0000_B588_0F0E_0D0C, 8'hFF, 1'b0, 16'd64};
    tbl[2] = '{2,  64'h1716_1514_1312_0000, 8'hFF, 1'b0, 16'd64};
    tbl[3] = '{7,  64'h3F3E_3D3C_3B3A_3938, 8'hFF, 1'b1, 16'd64};
    tbl[4] = '{8,  64'h0B0A_FFFF_FFFF_FFFF, 8'hFF, 1'b0, 16'd65};
    tbl[5] = '{10, 64'h1716_1514_1312_0100, 8'hFF, 1'b0, 16'd65};
    tbl[6] = '{15, 64'h3F3E_3D3C_3B3A_3938, 8'hFF, 1'b0, 16'd65};
    tbl[7] = '{16, 64'h0000_0000_0000_0040, 8'h01, 1'b1, 16'd65};
    lens = '{64, 65, 66, 64, 65};

    rst = 1'b1; en_a = 1'b0; en_b = 1'b0; tready_a = 1'b1; tready_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", tvalid_a, 1'b0);
    check("rst_tdata", tdata_a, 64'd0);
    check("rst_tkeep", tkeep_a, 8'd0);
    check("rst_tlast", tlast_a, 1'b0);
    check("rst_frame_cnt", fcnt_a, 32'd0);
    check("rst_cur_length", clen_a, 16'd0);
    check("rst_busy", busy_a, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    beats_a.delete();

    // Basic frames, one-cycle start latency, 4-cycle gap.
    @(posedge clk); #1;
    en_a = 1'b1;
    @(negedge clk);
    check("start_latency_low", tvalid_a, 1'b0);
    @(negedge clk);
    check("start_latency_high", tvalid_a, 1'b1);
    check("start_busy", busy_a, 1'b1);
    check("start_cur_length", clen_a, 16'd64);
    wait_beats_a(17, 300);
    if (beats_a.size() >= 17) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("vec%0d_beat%0d_tdata", i, tbl[i].idx), beats_a[tbl[i].idx].data, tbl[i].data);
        check($sformatf("vec%0d_beat%0d_tkeep", i, tbl[i].idx), beats_a[tbl[i].idx].keep, tbl[i].keep);
        check($sformatf("vec%0d_beat%0d_tlast", i, tbl[i].idx), beats_a[tbl[i].idx].last, tbl[i].last);
        check($sformatf("vec%0d_beat%0d_len", i, tbl[i].idx), beats_a[tbl[i].idx].cur_len, tbl[i].len);
      end
      check("gap_idle_cycles", beats_a[8].cyc - beats_a[7].cyc - 1, 4);
    end
    $display("test1 basic frames: %0d beats captured", beats_a.size());

    // 20 frames under random backpressure.
    do_reset();
    rand_ready = 1'b1;
    en_a = 1'b1;
    wait_frames(0, 20, 4000);
    @(posedge clk); #1;
    en_a = 1'b0;
    wait_idle_a(200, fall);
    rand_ready = 1'b0;
    tready_a = 1'b1;
    check("random_frame_cnt", fcnt_a, 32'd20);
    pos = 0;
    for (int i = 0; i < 20; i++) check_frame($sformatf("rand_f%0d", i), 0, pos, 64 + i, i);
    $display("test2 random tready: frame_cnt %0d", fcnt_a);

    // Enable dropped mid-frame: frame completes, gap, then idle.
    do_reset();
    en_a = 1'b1;
    wait_beats_a(3, 100);
    @(posedge clk); #1;
    en_a = 1'b0;
    wait_idle_a(100, fall);
    check("drop_beats", beats_a.size(), 8);
    pos = 0;
    check_frame("drop_f0", 0, pos, 64, 0);
    check("drop_frame_cnt", fcnt_a, 32'd1);
    if (beats_a.size() >= 8) check("drop_busy_fall", fall - beats_a[7].cyc, 5);
    vcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (tvalid_a) vcnt++;
    end
    check("drop_no_tvalid", vcnt, 0);
    $display("test4 enable drop: busy fell at cycle %0d", fall);

    // Reset mid-frame, then restart from length 64 / sequence 0.
    do_reset();
    en_a = 1'b1;
    wait_beats_a(19, 200);
    @(negedge clk); #2;
    rst = 1'b1;
    beats_a.delete();
    #1;
    check("midrst_tvalid", tvalid_a, 1'b0);
    check("midrst_tdata", tdata_a, 64'd0);
    check("midrst_frame_cnt", fcnt_a, 32'd0);
    check("midrst_busy", busy_a, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_beats_a(8, 100);
    pos = 0;
    check_frame("midrst_f0", 0, pos, 64, 0);
    $display("test6 mid-frame reset: %0d beats after restart", beats_a.size());

    // Short sweep 64..66 with zero gap on dut_b.
    do_reset();
    en_b = 1'b1;
    wait_frames(1, 5, 300);
    @(posedge clk); #1;
    en_b = 1'b0;
    pos = 0;
    for (int i = 0; i < 5; i++) check_frame($sformatf("sweep_f%0d", i), 1, pos, lens[i], i);
    bad = 0;
    for (int i = 1; i < 43 && i < beats_b.size(); i++)
      if (beats_b[i].cyc != beats_b[i-1].cyc + 1) bad++;
    check("b2b_gaps", bad, 0);
    if (beats_b.size() >= 9) begin
      check("b2b_tlast", beats_b[7].last, 1'b1);
      check("b2b_next_header", beats_b[8].data, 64'h0B0A_FFFF_FFFF_FFFF);
      check("b2b_next_cycle", beats_b[8].cyc - beats_b[7].cyc, 1);
    end
    $display("test3/5 sweep+b2b: %0d beats captured", beats_b.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_frame_gen.md
Name: eth_frame_gen

Overview:
AXI-Stream Ethernet test-frame generator. It feeds the TX user interface of one 40G MAC channel in the VCU128 40G Ethernet top; one instance is built per channel (P_CHANNEL_NUM).
Frames carry a fixed header, a 32-bit sequence number and a deterministic byte pattern. Frame length sweeps from P_MIN_LENGTH to P_MAX_LENGTH, so the loopback RX checker can predict every byte.
Frame length excludes FCS; the MAC appends the FCS.

Parameters:
P_MIN_LENGTH, 8'd64, first/minimum frame length in bytes (legal range 18..255).
P_MAX_LENGTH, 15'd9600, maximum frame length in bytes (must be >= P_MIN_LENGTH).
P_LEN_STEP, 16'd1, length increment per frame.
P_GAP_CYCLES, 8'd4, idle cycles between frames (0 allowed).
P_DST_MAC, 48'hFFFF_FFFF_FFFF, destination MAC.
P_SRC_MAC, 48'h0A0B_0C0D_0E0F, source MAC.
P_ETH_TYPE, 16'h88B5, EtherType field.

Ports:
i_clk  input  1  MAC TX user clock
i_rst  input  1  asynchronous active-high reset
i_enable  input  1  level; high = generate frames continuously
o_axis_tdata  output  64  frame data; byte 0 of a beat in [7:0]
o_axis_tkeep  output  8  byte-valid mask, LSB = byte 0
o_axis_tlast  output  1  last beat of frame
o_axis_tvalid  output  1  beat valid
i_axis_tready  input  1  MAC ready
o_frame_cnt  output  32  completed frames (tlast handshakes)
o_cur_length  output  16  length of the frame being or last sent
o_busy  output  1  high when not in IDLE

Behaviour:
- Reset (asynchronous, active-high): all outputs 0; FSM in IDLE; length register = P_MIN_LENGTH; sequence = 0.
- Handshake:
  - A beat transfers when tvalid && tready.
  - While tvalid is high and tready is low, tdata, tkeep and tlast are held stable.
  - tvalid is never deasserted mid-frame without a handshake.
- FSM states: IDLE, SEND, GAP.
  - IDLE -> SEND when i_enable = 1. On this transition: length = P_MIN_LENGTH, sequence = 0. tvalid rises the next cycle (1-cycle latency).
  - SEND -> GAP on the tlast handshake.
  - SEND -> IDLE on the tlast handshake when P_GAP_CYCLES = 0 and i_enable = 0.
  - GAP: counts exactly P_GAP_CYCLES cycles with tvalid = 0, then goes to SEND if i_enable = 1, else IDLE.
  - P_GAP_CYCLES = 0: the next frame's first beat is presented in the cycle after tlast (back-to-back).
- i_enable low during SEND: the current frame completes; no frame is ever truncated.
- Frame content for byte index k (0-based):
  - k 0-5: P_DST_MAC, MSB first.
  - k 6-11: P_SRC_MAC, MSB first.
  - k 12-13: P_ETH_TYPE, MSB first.
  - k 14-17: sequence number, big-endian.
  - k >= 18: k[7:0].
- Beats: beats per frame = ceil(L/8). Last beat tkeep = (1 << r) - 1, where r = L - 8*(beats-1) (1..8); all other beats tkeep = 8'hFF. Bytes not marked valid in tkeep are driven 0.
- Length update, after each tlast handshake:
  - next = L + P_LEN_STEP (computed 16-bit, no overflow for legal params).
  - If next > P_MAX_LENGTH, the length wraps to P_MIN_LENGTH.
  - Sequence increments by 1 and wraps at 2^32.
- o_frame_cnt increments on every tlast handshake and wraps at 2^32. It is not cleared by i_enable.
- o_cur_length updates when a frame's first beat is first presented.
- Reset asserted mid-frame: outputs go to 0 immediately; no completion of the frame.

Optional Feature:
Macro FRAME_GEN_RAND_LEN_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16, 14, 13, 11; seed 16'hACE1; reloaded on reset and on IDLE->SEND) advances once per tlast handshake.
  - Next length = P_MIN_LENGTH + lfsr[13:0], clamped to P_MAX_LENGTH.
  - The first frame after IDLE still uses P_MIN_LENGTH.
- Undefined: sequential sweep as above; no LFSR logic is synthesized.

Test Plan:
1. Defaults, i_enable = 1, tready = 1 -> frame 0: 8 beats, last tkeep 8'hFF. Beat 0 tdata = 64'h0B0AFFFFFFFFFFFF. Frame 1 is 65 bytes: 9 beats, last beat tkeep 8'h01, data byte 0 = 8'h40. Gap between frames = 4 cycles.
2. Random tready (50%) over 20 frames -> payload and sequence numbers 0..19 match the model; data held stable during every stall; o_frame_cnt = 20.
3. P_MIN_LENGTH = 64, P_MAX_LENGTH = 66, P_LEN_STEP = 1 -> lengths 64, 65, 66, 64, 65. Byte-count wraps exactly at 66.
4. Drop i_enable on beat 3 of a 64-byte frame -> all 8 beats are sent, then GAP, then IDLE; o_busy falls after the 4 gap cycles; no further tvalid.
5. P_GAP_CYCLES = 0 -> tvalid stays high continuously across frame boundaries; tlast is followed immediately by the next frame's header.
6. Assert i_rst mid-frame, then re-enable -> tvalid = 0 immediately; o_frame_cnt = 0; the next frame has length 64 and sequence 0.
